// File: rtl/aging_pkg.sv
// Shared types and constants for the aging-sensor FIFO read-side logic.
package aging_pkg;

  localparam int unsigned AGING_SAMPLE_W = 8;

  typedef enum logic [0:0] {
    FILL,
    HOLD
  } drain_state_e;

endpackage

// File: rtl/aging_fifo_drain_if.sv
// Signal bundle between the aging FIFO read port, the drain engine and the SoC consumer.
// master = drain engine, slave = FIFO/consumer side.
interface aging_fifo_drain_if #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned CNT_W      = 16
) ();
  import aging_pkg::*;

  logic                                  fifo_empty;
  logic [AGING_SAMPLE_W-1:0]             fifo_q;
  logic                                  fifo_rdreq;
  logic                                  flush;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [AGING_SAMPLE_W*WORD_BYTES-1:0]  out_data;
  logic [2:0]                            out_bytes;
  logic [CNT_W-1:0]                      word_count;

  modport master (
    input  fifo_empty,
    input  fifo_q,
    input  flush,
    input  out_ready,
    output fifo_rdreq,
    output out_valid,
    output out_data,
    output out_bytes,
    output word_count
  );

  modport slave (
    output fifo_empty,
    output fifo_q,
    output flush,
    output out_ready,
    input  fifo_rdreq,
    input  out_valid,
    input  out_data,
    input  out_bytes,
    input  word_count
  );

endinterface

// File: rtl/aging_idle_timer.sv
// Idle counter: clear dominates, counts while enabled, and pulses expire for one cycle on the
// enabled cycle that brings the count to Threshold.
module aging_idle_timer #(
  parameter int unsigned Threshold = 64
) (
  input  logic clock,
  input  logic sclr,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned Width = $clog2(Threshold + 1);

  logic [Width-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == Width'(Threshold - 1));
  assign o_expire  = i_enable && !i_clear && w_at_last;

  always_ff @(posedge clock) begin
    if (sclr || i_clear || o_expire) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + Width'(1);
    end
  end

endmodule

// File: rtl/aging_fifo_drain.sv
// Read-side drain engine: pops 8-bit aging samples from a show-ahead FIFO, packs them LSB-first
// into words and offers each word with valid/ready; partial words leave on flush or idle timeout.
module aging_fifo_drain
  import aging_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clock,
  input  logic               sclr,
  aging_fifo_drain_if.master bus
);

  localparam int unsigned DataW = AGING_SAMPLE_W * WORD_BYTES;
  localparam int unsigned BcntW = 3;
  localparam logic [BcntW-1:0] FullCnt = BcntW'(WORD_BYTES);

  drain_state_e     r_state, w_state_next;
  logic [BcntW-1:0] r_cnt, w_cnt_next;
  logic [DataW-1:0] r_data, w_data_next;
  logic [BcntW-1:0] r_out_bytes, w_out_bytes_next;
  logic [CNT_W-1:0] r_word_count, w_word_count_next;

  logic             w_pop;
  logic [BcntW-1:0] w_cnt_inc;
  logic [DataW-1:0] w_data_pop;
  logic             w_timer_clear;
  logic             w_timer_enable;
  logic             w_expire;

  // FIFO is show-ahead, so the request itself is the pop for this edge.
  assign w_pop     = (r_state == FILL) && !bus.fifo_empty && !sclr;
  assign w_cnt_inc = r_cnt + BcntW'(w_pop);

  always_comb begin
    w_data_pop = r_data;
    for (int i = 0; i < int'(WORD_BYTES); i++) begin
      if (w_pop && (r_cnt == BcntW'(i))) begin
        w_data_pop[i*AGING_SAMPLE_W +: AGING_SAMPLE_W] = bus.fifo_q;
      end
    end
  end

  assign w_timer_clear  = w_pop || (r_cnt == '0);
  assign w_timer_enable = (r_state == FILL) && bus.fifo_empty;

  aging_idle_timer #(
    .Threshold (TIMEOUT)
  ) u_idle_timer (
    .clock    (clock),
    .sclr     (sclr),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_enable),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_data_next       = r_data;
    w_out_bytes_next  = r_out_bytes;
    w_word_count_next = r_word_count;
    unique case (r_state)
      FILL: begin
        w_cnt_next  = w_cnt_inc;
        w_data_next = w_data_pop;
        // A completed word wins over flush/timeout so HOLD is entered exactly once.
        if (w_cnt_inc == FullCnt) begin
          w_state_next     = HOLD;
          w_out_bytes_next = FullCnt;
        end else if ((bus.flush || w_expire) && (w_cnt_inc != '0)) begin
          w_state_next     = HOLD;
          w_out_bytes_next = w_cnt_inc;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_state_next      = FILL;
          w_cnt_next        = '0;
          w_data_next       = '0;
          w_out_bytes_next  = '0;
          w_word_count_next = r_word_count + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = FILL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      r_state      <= FILL;
      r_cnt        <= '0;
      r_data       <= '0;
      r_out_bytes  <= '0;
      r_word_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_data       <= w_data_next;
      r_out_bytes  <= w_out_bytes_next;
      r_word_count <= w_word_count_next;
    end
  end

  assign bus.fifo_rdreq = w_pop;
  assign bus.out_valid  = (r_state == HOLD);
  assign bus.out_data   = r_data;
  assign bus.out_bytes  = r_out_bytes;
  assign bus.word_count = r_word_count;

  a_no_pop_when_empty : assert property (@(posedge clock) bus.fifo_rdreq |-> !bus.fifo_empty);

  a_hold_stable : assert property (@(posedge clock) disable iff (sclr)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_bytes)));

  a_bytes_range : assert property (@(posedge clock) disable iff (sclr)
    bus.out_valid |-> ((bus.out_bytes != '0) && (bus.out_bytes <= FullCnt)));

endmodule

// File: tb/tb_aging_fifo_drain.sv
// Randomized bench for aging_fifo_drain against a queue-based behavioural model of the drain.
module tb_aging_fifo_drain;

  localparam int WB = 4;
  localparam int TO = 64;
  localparam int CW = 4;

  logic clock = 1'b0;
  logic sclr;
  always #5 clock = ~clock;

  aging_fifo_drain_if #(.WORD_BYTES(WB), .CNT_W(CW)) bus ();

  aging_fifo_drain #(
    .WORD_BYTES (WB),
    .TIMEOUT    (TO),
    .CNT_W      (CW)
  ) dut (
    .clock (clock),
    .sclr  (sclr),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  fifo_mem[$];
  logic [7:0]  sb_in[$];
  logic [7:0]  got_stream[$];
  logic [31:0] got_data[$];
  int          got_bytes[$];
  logic        stall = 1'b0;
  bit          chk_en = 1'b0;
  int          cyc_err = 0;
  string       first_err = "";
  int          n_rdreq = 0;

  // Behavioural model: pending bytes, held word, handshake count, idle age.
  bit          m_hold = 1'b0;
  logic [7:0]  m_pend[$];
  logic [31:0] m_word = '0;
  int          m_nbytes = 0;
  int          m_wc = 0;
  int          m_idle = 0;

  function automatic void note(string what, logic [31:0] act, logic [31:0] exp);
    cyc_err++;
    if (first_err == "") first_err = $sformatf("%s @%0t got=%0h want=%0h", what, $time, act, exp);
  endfunction

  task automatic drive_fifo();
    bus.fifo_empty = (fifo_mem.size() == 0) || stall;
    bus.fifo_q     = (fifo_mem.size() > 0) ? fifo_mem[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem.push_back(b);
    sb_in.push_back(b);
    drive_fifo();
  endtask

  task automatic begin_test();
    cyc_err   = 0;
    first_err = "";
    n_rdreq   = 0;
  endtask

  task automatic tick();
    logic exp_rdreq;
    logic s_rdreq;
    @(negedge clock);
    exp_rdreq = !m_hold && !bus.fifo_empty && !sclr;
    s_rdreq   = (bus.fifo_rdreq === 1'b1);
    if (chk_en) begin
      if (bus.fifo_rdreq !== exp_rdreq) note("fifo_rdreq", 32'(bus.fifo_rdreq), 32'(exp_rdreq));
      if (bus.out_valid !== m_hold) note("out_valid", 32'(bus.out_valid), 32'(m_hold));
      if (bus.word_count !== CW'(m_wc)) note("word_count", 32'(bus.word_count), 32'(m_wc));
      if (m_hold && (bus.out_data !== m_word)) note("out_data", bus.out_data, m_word);
      if (m_hold && (bus.out_bytes !== 3'(m_nbytes)))
        note("out_bytes", 32'(bus.out_bytes), 32'(m_nbytes));
      if (s_rdreq && bus.fifo_empty) note("pop_when_empty", 32'd1, 32'd0);
      if ((bus.out_valid === 1'b1) && bus.out_ready && !sclr) begin
        got_data.push_back(bus.out_data);
        got_bytes.push_back(int'(bus.out_bytes));
        for (int i = 0; i < int'(bus.out_bytes); i++) got_stream.push_back(bus.out_data[8*i +: 8]);
      end
    end
    if (s_rdreq) n_rdreq++;
    if (sclr) begin
      m_hold = 1'b0;
      m_pend.delete();
      m_wc   = 0;
      m_idle = 0;
    end else if (!m_hold) begin
      if (exp_rdreq) begin
        m_pend.push_back(fifo_mem[0]);
        m_idle = 0;
      end else if (m_pend.size() > 0) begin
        m_idle++;
      end
      if ((m_pend.size() == WB) || ((m_pend.size() > 0) && (bus.flush || (m_idle == TO)))) begin
        m_word = '0;
        foreach (m_pend[i]) m_word = m_word | (32'(m_pend[i]) << (8 * i));
        m_nbytes = m_pend.size();
        m_pend.delete();
        m_idle = 0;
        m_hold = 1'b1;
      end
    end else if (bus.out_ready) begin
      m_hold = 1'b0;
      m_wc   = (m_wc + 1) % (1 << CW);
    end
    @(posedge clock);
    #1;
    if (s_rdreq && (fifo_mem.size() > 0)) void'(fifo_mem.pop_front());
    drive_fifo();
  endtask

  task automatic wait_words(input int target, input int budget);
    for (int k = 0; k < budget && got_data.size() < target; k++) tick();
  endtask

  task automatic test_reset();
    begin_test();
    sclr = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive_fifo();
    tick();
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h want=0", bus.out_data); end
    n_checks++; if (bus.out_bytes !== 3'd0) begin n_fail++; $display("FAIL reset_bytes got=%0d want=0", bus.out_bytes); end
    n_checks++; if (bus.word_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", bus.word_count); end
    n_checks++; if (bus.fifo_rdreq !== 1'b0) begin n_fail++; $display("FAIL reset_rdreq got=%b want=0", bus.fifo_rdreq); end
    sclr = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic test_single_word();
    begin_test();
    bus.out_ready = 1'b1;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    wait_words(1, 20);
    n_checks++; if (got_data.size() !== 1) begin n_fail++; $display("FAIL single_nwords got=%0d want=1", got_data.size()); end
    n_checks++; if (got_data.size() > 0 && got_data[0] !== 32'h44332211) begin n_fail++; $display("FAIL single_data got=%h want=44332211", got_data[0]); end
    n_checks++; if (got_bytes.size() > 0 && got_bytes[0] !== 4) begin n_fail++; $display("FAIL single_bytes got=%0d want=4", got_bytes[0]); end
    n_checks++; if (bus.word_count !== 4'd1) begin n_fail++; $display("FAIL single_count got=%0d want=1", bus.word_count); end
    n_checks++; if (n_rdreq !== 4) begin n_fail++; $display("FAIL single_rdreq got=%0d want=4", n_rdreq); end
    n_checks++; if (cyc_err !== 0) begin n_fail++; $display("FAIL single_model errors=%0d want=0 %s", cyc_err, first_err); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[8];
    logic [31:0] w1, w2;
    int base;
    begin_test();
    base = got_data.size();
    bus.out_ready = 1'b0;
    foreach (b[i]) begin b[i] = 8'($urandom); push_byte(b[i]); end
    w1 = {b[3], b[2], b[1], b[0]};
    w2 = {b[7], b[6], b[5], b[4]};
    for (int k = 0; k < 10; k++) tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got=%b want=1", bus.out_valid); end
    n_checks++; if (bus.out_data !== w1) begin n_fail++; $display("FAIL bp_held_data got=%h want=%h", bus.out_data, w1); end
    n_checks++; if (fifo_mem.size() !== 4) begin n_fail++; $display("FAIL bp_fifo_left got=%0d want=4", fifo_mem.size()); end
    n_checks++; if (n_rdreq !== 4) begin n_fail++; $display("FAIL bp_rdreq got=%0d want=4", n_rdreq); end
    bus.out_ready = 1'b1;
    wait_words(base + 2, 30);
    n_checks++; if (got_data.size() !== base + 2) begin n_fail++; $display("FAIL bp_nwords got=%0d want=%0d", got_data.size(), base + 2); end
    n_checks++; if (got_data.size() >= base + 2 && (got_data[base] !== w1 || got_data[base+1] !== w2)) begin n_fail++; $display("FAIL bp_order got=%h,%h want=%h,%h", got_data[base], got_data[base+1], w1, w2); end
    n_checks++; if (cyc_err !== 0) begin n_fail++; $display("FAIL bp_model errors=%0d want=0 %s", cyc_err, first_err); end
  endtask

  task automatic test_timeout();
    int k;
    int base;
    begin_test();
    base = got_data.size();
    bus.out_ready = 1'b1;
    push_byte(8'hA1); push_byte(8'hB2);
    tick(); tick();
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 3 * TO) begin tick(); k++; end
    n_checks++; if (k !== TO) begin n_fail++; $display("FAIL timeout_cycles got=%0d want=%0d", k, TO); end
    n_checks++; if (bus.out_data !== 32'h0000B2A1) begin n_fail++; $display("FAIL timeout_data got=%h want=0000b2a1", bus.out_data); end
    n_checks++; if (bus.out_bytes !== 3'd2) begin n_fail++; $display("FAIL timeout_bytes got=%0d want=2", bus.out_bytes); end
    tick();
    n_checks++; if (got_data.size() !== base + 1) begin n_fail++; $display("FAIL timeout_nwords got=%0d want=%0d", got_data.size(), base + 1); end
    n_checks++; if (cyc_err !== 0) begin n_fail++; $display("FAIL timeout_model errors=%0d want=0 %s", cyc_err, first_err); end
  endtask

  task automatic test_flush();
    logic [7:0] b[5];
    int base;
    begin_test();
    bus.out_ready = 1'b1;
    foreach (b[i]) b[i] = 8'($urandom);
    push_byte(b[0]); push_byte(b[1]); push_byte(b[2]);
    tick(); tick();
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    n_checks++; if (bus.out_bytes !== 3'd3 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush3_bytes got=%0d/%b want=3/1", bus.out_bytes, bus.out_valid); end
    n_checks++; if (bus.out_data !== {8'h00, b[2], b[1], b[0]}) begin n_fail++; $display("FAIL flush3_data got=%h want=%h", bus.out_data, {8'h00, b[2], b[1], b[0]}); end
    tick();
    base = got_data.size();
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (got_data.size() !== base || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_ignored nwords=%0d valid=%b want=%0d/0", got_data.size(), bus.out_valid, base); end
    push_byte(b[0]); push_byte(b[1]); push_byte(b[2]); push_byte(b[3]);
    tick(); tick(); tick();
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    n_checks++; if (bus.out_bytes !== 3'd4 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_full_bytes got=%0d/%b want=4/1", bus.out_bytes, bus.out_valid); end
    tick();
    base = got_data.size();
    bus.out_ready = 1'b0;
    push_byte(b[0]); push_byte(b[1]); push_byte(b[2]); push_byte(b[3]); push_byte(b[4]);
    for (int k = 0; k < 4; k++) tick();
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    n_checks++; if (got_data.size() !== base + 1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hold_not_queued nwords=%0d valid=%b want=%0d/0", got_data.size(), bus.out_valid, base + 1); end
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    n_checks++; if (bus.out_bytes !== 3'd1 || bus.out_data !== {24'h0, b[4]}) begin n_fail++; $display("FAIL flush1_word got=%0d/%h want=1/%h", bus.out_bytes, bus.out_data, {24'h0, b[4]}); end
    tick();
    n_checks++; if (cyc_err !== 0) begin n_fail++; $display("FAIL flush_model errors=%0d want=0 %s", cyc_err, first_err); end
  endtask

  task automatic test_sclr();
    logic [7:0] c[4];
    int base;
    begin_test();
    bus.out_ready = 1'b1;
    push_byte(8'h5A); push_byte(8'hA5);
    tick(); tick();
    foreach (c[i]) begin c[i] = 8'($urandom); push_byte(c[i]); end
    sclr = 1'b1;
    #1;
    n_checks++; if (bus.fifo_rdreq !== 1'b0) begin n_fail++; $display("FAIL sclr_rdreq got=%b want=0", bus.fifo_rdreq); end
    tick();
    sclr = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.word_count !== 4'd0) begin n_fail++; $display("FAIL sclr_state valid=%b count=%0d want=0/0", bus.out_valid, bus.word_count); end
    base = got_data.size();
    wait_words(base + 1, 20);
    n_checks++; if (got_data.size() !== base + 1 || got_data[got_data.size()-1] !== {c[3], c[2], c[1], c[0]}) begin n_fail++; $display("FAIL sclr_clean_word got=%h want=%h", got_data[got_data.size()-1], {c[3], c[2], c[1], c[0]}); end
    n_checks++; if (bus.word_count !== 4'd1) begin n_fail++; $display("FAIL sclr_count got=%0d want=1", bus.word_count); end
    n_checks++; if (cyc_err !== 0) begin n_fail++; $display("FAIL sclr_model errors=%0d want=0 %s", cyc_err, first_err); end
  endtask

  task automatic test_wrap_random();
    int base;
    int pushed;
    int mism;
    begin_test();
    sclr = 1'b1; tick(); sclr = 1'b0;
    bus.out_ready = 1'b1;
    base = got_data.size();
    for (int i = 0; i < 17 * WB; i++) push_byte(8'($urandom));
    wait_words(base + 17, 200);
    n_checks++; if (bus.word_count !== 4'd1) begin n_fail++; $display("FAIL wrap_count got=%0d want=1", bus.word_count); end
    sb_in.delete();
    got_stream.delete();
    pushed = 0;
    for (int c = 0; c < 800; c++) begin
      if (pushed < 200 && $urandom_range(0, 1) == 1) begin push_byte(8'($urandom)); pushed++; end
      stall = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      drive_fifo();
      tick();
    end
    stall = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive_fifo();
    for (int k = 0; k < 500 && (fifo_mem.size() > 0 || bus.out_valid === 1'b1); k++) tick();
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    tick(); tick();
    n_checks++; if (got_stream.size() !== sb_in.size()) begin n_fail++; $display("FAIL rand_nbytes got=%0d want=%0d", got_stream.size(), sb_in.size()); end
    mism = -1;
    for (int i = 0; i < sb_in.size() && i < got_stream.size(); i++)
      if (mism < 0 && got_stream[i] !== sb_in[i]) mism = i;
    n_checks++; if (mism !== -1) begin n_fail++; $display("FAIL rand_byte_order first_bad_index=%0d want=-1", mism); end
    n_checks++; if (bus.word_count !== CW'(m_wc)) begin n_fail++; $display("FAIL rand_count got=%0d want=%0d", bus.word_count, m_wc); end
    n_checks++; if (cyc_err !== 0) begin n_fail++; $display("FAIL rand_model errors=%0d want=0 %s", cyc_err, first_err); end
  endtask

  initial begin
    sclr = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive_fifo();
    test_reset();
    test_single_word();
    test_backpressure();
    test_timeout();
    test_flush();
    test_sclr();
    test_wrap_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
